// File: rtl/mips_pkg.sv
// mips_pkg: shared loader state encoding and sizing constants
package mips_pkg;
  typedef enum logic [2:0] {S_CNT_HI, S_CNT_LO, S_DATA, S_CSUM, S_DONE, S_ERR} loader_state_t;
  localparam int LDR_CNT_W = 16;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: assembles accepted bytes MSB-first into 32-bit words
module imem_byte_packer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [23:0] sr_q, sr_d;
  always_comb begin
    byte_idx_d = acc ? byte_idx_q + 2'd1 : byte_idx_q;
    sr_d = acc ? {sr_q[15:0], byte_in} : sr_q;
    word_valid = acc && byte_idx_q == 2'(WORD_BYTES - 1);
    word = {sr_q, byte_in};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_idx_q <= '0;
      sr_q <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      sr_q <= sr_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader streaming a counted word image into imem, core held in reset until done
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int MAX_WORDS = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t FIN = S_CSUM;
`else
  localparam loader_state_t FIN = S_DONE;
`endif
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  loader_state_t state_q, state_d;
  logic [LDR_CNT_W-1:0] cnt_q, cnt_d, word_idx_q, word_idx_d;
  logic imem_we_q, imem_we_d, core_rst_n_q, core_rst_n_d;
  logic load_done_q, load_done_d, load_err_q, load_err_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0] imem_wdata_q, imem_wdata_d, word;
  logic acc, pk_acc, word_valid;
  assign in_ready = rst_n && state_q != S_DONE && state_q != S_ERR;
  assign acc = in_valid && in_ready;
  assign pk_acc = acc && state_q == S_DATA;
  imem_byte_packer u_packer (
    .clk(clk), .rst_n(rst_n), .acc(pk_acc), .byte_in(in_data),
    .word_valid(word_valid), .word(word)
  );
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;
  assign xor_d = pk_acc ? xor_q ^ in_data : xor_q;
  always_ff @(posedge clk) xor_q <= !rst_n ? 8'h00 : xor_d;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    word_idx_d = word_idx_q;
    imem_we_d = word_valid;
    imem_addr_d = word_valid ? BASE + ADDR_W'({word_idx_q, 2'b00}) : imem_addr_q;
    imem_wdata_d = word_valid ? word : imem_wdata_q;
    core_rst_n_d = state_q == S_DONE;
    load_done_d = state_q == S_DONE;
    load_err_d = state_q == S_ERR;
    if (acc && state_q == S_CNT_HI) begin
      cnt_d = {in_data, 8'h00};
      state_d = S_CNT_LO;
    end
    if (acc && state_q == S_CNT_LO) begin
      cnt_d = {cnt_q[15:8], in_data};
      state_d = cnt_d == '0 ? FIN : (32'(cnt_d) > 32'(MAX_WORDS) ? S_ERR : S_DATA);
    end
    if (state_q == S_DATA && word_valid) begin
      word_idx_d = word_idx_q + 16'd1;
      state_d = word_idx_q == cnt_q - 16'd1 ? FIN : S_DATA;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (acc && state_q == S_CSUM) state_d = in_data == xor_q ? S_DONE : S_ERR;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_CNT_HI;
      cnt_q <= '0;
      word_idx_q <= '0;
      imem_we_q <= 1'b0;
      imem_addr_q <= BASE;
      imem_wdata_q <= '0;
      core_rst_n_q <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      word_idx_q <= word_idx_d;
      imem_we_q <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      load_done_q <= load_done_d;
      load_err_q <= load_err_d;
    end
  end
  assign imem_we = imem_we_q;
  assign imem_addr = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign load_done = load_done_q;
  assign load_err = load_err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader; honours IMEM_LOADER_CHECKSUM_EN
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, imem_we, core_rst_n, load_done, load_err;
  logic [31:0] imem_addr, imem_wdata;
  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(256), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .load_done(load_done), .load_err(load_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (imem_we) begin
      logic [63:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got addr=%h data=%h expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (imem_addr !== e[63:32] || imem_wdata !== e[31:0]) begin
          failures++;
          $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                   imem_addr, imem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end
  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    logic r;
    bit ok;
    g = maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0;
    ok = 1'b0;
    in_valid = 1'b0;
    repeat (g) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data = b;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk) r = in_ready;
      @(posedge clk);
      #1;
      ok = r;
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout byte=%h got no accept expected accept within 20 cycles", b);
    end
  endtask
  task automatic send_image(input int cnt, input logic [31:0] w[$], input int maxgap, input bit bad_csum);
    logic [15:0] c;
    logic [7:0] x;
    c = 16'(cnt);
    x = 8'h00;
    send_byte(c[15:8], maxgap);
    send_byte(c[7:0], maxgap);
    for (int i = 0; i < cnt; i++) begin
      logic [31:0] wd;
      wd = w[i];
      for (int k = 3; k >= 0; k--) begin
        if (k == 0) exp_q.push_back({32'(4 * i), wd});
        x ^= wd[8*k +: 8];
        send_byte(wd[8*k +: 8], maxgap);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? x ^ 8'h01 : x, maxgap);
`endif
  endtask
  task automatic check_done(input string name);
    checks++;
    if (load_done !== 1'b0) begin failures++; $display("FAIL %s_done_early got %b expected 0", name, load_done); end
    @(posedge clk); #1;
    checks++;
    if ({load_done, core_rst_n, load_err, in_ready} !== 4'b1100) begin
      failures++;
      $display("FAIL %s_done got done/core_rst_n/err/ready=%b expected 1100", name, {load_done, core_rst_n, load_err, in_ready});
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_pending got %0d writes outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_low got %b expected 0", in_ready); end
    checks++;
    if ({imem_we, core_rst_n, load_done, load_err} !== 4'b0000 || imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_vals got we/crst/done/err=%b addr=%h data=%h expected 0000 0 0",
               {imem_we, core_rst_n, load_done, load_err}, imem_addr, imem_wdata);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_high got %b expected 1", in_ready); end
  endtask
  task automatic test_two_words(input int maxgap, input string name);
    logic [31:0] w[$];
    w = {32'h20080005, 32'h01095020};
    do_reset();
    send_image(2, w, maxgap, 1'b0);
    check_done(name);
  endtask
  task automatic test_zero_count();
    logic [31:0] w[$];
    do_reset();
    send_image(0, w, 0, 1'b0);
    check_done("zero");
  endtask
  task automatic test_count_err();
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL cnt_err_ready got %b expected 0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if ({load_err, core_rst_n, load_done} !== 3'b100) begin
      failures++;
      $display("FAIL cnt_err got err/crst/done=%b expected 100", {load_err, core_rst_n, load_done});
    end
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    @(posedge clk); #1;
    checks++;
    if ({in_ready, load_err, load_done} !== 3'b100) begin
      failures++;
      $display("FAIL cnt_max_ok got ready/err/done=%b expected 100", {in_ready, load_err, load_done});
    end
  endtask
  task automatic test_reset_mid();
    logic [31:0] w[$];
    w = {32'h11223344};
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_image(1, w, 0, 1'b0);
    check_done("reset_mid");
  endtask
`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [31:0] w[$];
    w = {32'h12345678};
    do_reset();
    send_image(1, w, 0, 1'b0);
    check_done("csum_ok");
    do_reset();
    exp_q.push_back({32'h0, 32'h12345678});
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    send_byte(8'h09, 0);
    @(posedge clk); #1;
    checks++;
    if ({load_err, core_rst_n, load_done, in_ready} !== 4'b1000) begin
      failures++;
      $display("FAIL csum_bad got err/crst/done/ready=%b expected 1000", {load_err, core_rst_n, load_done, in_ready});
    end
  endtask
`endif
  initial begin
    test_reset();
    test_two_words(0, "two_words");
    test_zero_count();
    test_count_err();
    test_reset_mid();
    test_two_words(5, "gaps");
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL final_pending got %0d expected 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
